// File: rtl/hamming_stream_encoder.sv
// Two-stage elastic valid/ready Hamming encoder (even parity, parity bits at powers of two).
// Define HAMMING_SECDED_EN to append an overall-parity MSB that makes the codeword SECDED.
module hamming_stream_encoder #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16,
  localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
  localparam int OUT_W  = CODE_W + 1
`else
  localparam int OUT_W  = CODE_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W:1]    D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W:1]     hammingCode,
  output logic [COUNT_W-1:0] word_count
);

  logic                      r_s1_valid;
  logic [DATA_W:1]           r_s1_data;
  logic                      r_out_valid;
  logic [OUT_W:1]            r_out_code;
  logic [COUNT_W-1:0]        r_word_count;

  logic                      w_out_ready_int;
  logic                      w_s1_ready;
  logic [CODE_W:1]           w_data_pos;
  logic [PAR_W-1:0][CODE_W:1] w_terms;
  logic [PAR_W-1:0]          w_par;
  logic [CODE_W:1]           w_code;
  logic [OUT_W:1]            w_code_full;

  // Each stage accepts when empty or when its current word leaves this cycle.
  assign w_out_ready_int = !r_out_valid || out_ready;
  assign w_s1_ready      = !r_s1_valid || w_out_ready_int;
  assign in_ready        = w_s1_ready;

  // Position p is a data slot unless it is a power of two; the data index is p
  // minus the number of powers of two at or below p.
  for (genvar p = 1; p <= CODE_W; p++) begin : g_pos
    if ((p & (p - 1)) != 0) begin : g_data
      assign w_data_pos[p] = r_s1_data[p - $clog2(p + 1)];
      assign w_code[p]     = w_data_pos[p];
    end else begin : g_parity
      assign w_data_pos[p] = 1'b0;
      assign w_code[p]     = w_par[$clog2(p)];
    end
    for (genvar k = 0; k < PAR_W; k++) begin : g_cover
      if (((p >> k) & 1) == 1) begin : g_in
        assign w_terms[k][p] = w_data_pos[p];
      end else begin : g_out
        assign w_terms[k][p] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < PAR_W; k++) begin : g_par
    assign w_par[k] = ^w_terms[k];
  end

`ifdef HAMMING_SECDED_EN
  assign w_code_full = {^w_code, w_code};
`else
  assign w_code_full = w_code;
`endif

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge values of its neighbours, which is what makes drain+load safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_code   <= '0;
      r_word_count <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_out_ready_int) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_code <= w_code_full;
        end
      end
      if (r_out_valid && out_ready) begin
        r_word_count <= r_word_count + 1'b1;
      end
    end
  end

  // NOTE: the s1 data register carries no reset; r_s1_valid qualifies it, so
  // its contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (w_s1_ready && in_valid) begin
      r_s1_data <= D;
    end
  end

  assign out_valid   = r_out_valid;
  assign hammingCode = r_out_code;
  assign word_count  = r_word_count;

`ifndef SYNTHESIS
  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_code)));
`endif

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed and randomized bench for hamming_stream_encoder (DATA_W=8), with a
// second COUNT_W=4 instance sharing the stimulus to exercise counter wrap.
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int OUT_W = 13;
  localparam logic [OUT_W:1] EXP_A1 = 13'h1A0D;
  localparam logic [OUT_W:1] EXP_56 = 13'h1531;
`else
  localparam int OUT_W = 12;
  localparam logic [OUT_W:1] EXP_A1 = 12'hA0D;
  localparam logic [OUT_W:1] EXP_56 = 12'h531;
`endif

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [8:1]      D;
  logic            out_valid;
  logic            out_ready;
  logic [OUT_W:1]  hammingCode;
  logic [15:0]     word_count;

  logic            in_ready_w4;
  logic            out_valid_w4;
  logic [OUT_W:1]  code_w4;
  logic [3:0]      count_w4;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;
  logic [7:0] sb_q[$];

  hamming_stream_encoder #(.DATA_W(8), .COUNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .hammingCode(hammingCode),
    .word_count(word_count)
  );

  hamming_stream_encoder #(.DATA_W(8), .COUNT_W(4)) u_dut_w4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w4), .D(D),
    .out_valid(out_valid_w4), .out_ready(out_ready), .hammingCode(code_w4),
    .word_count(count_w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Recover data bits from the non-power-of-two positions, D1 first.
  function automatic logic [7:0] extract_data(input logic [12:1] c);
    logic [12:1] t;
    logic [7:0]  d;
    logic [3:0]  pos;
    t = c; d = '0; pos = 4'd1;
    for (int n = 0; n < 12; n++) begin
      if ((pos & (pos - 4'd1)) != 4'd0) d = {t[1], d[7:1]};
      t = t >> 1;
      pos = pos + 4'd1;
    end
    return d;
  endfunction

  function automatic logic [3:0] index_xor(input logic [12:1] c);
    logic [12:1] t;
    logic [3:0]  pos;
    logic [3:0]  syn;
    t = c; pos = 4'd1; syn = '0;
    for (int n = 0; n < 12; n++) begin
      if (t[1]) syn = syn ^ pos;
      t = t >> 1;
      pos = pos + 4'd1;
    end
    return syn;
  endfunction

  // Scoreboard: record accepted words, compare every delivered codeword.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      exp_count = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(hammingCode), 64'(0));
        end else begin
          check("stream_data", 64'(extract_data(hammingCode[12:1])), 64'(sb_q[0]));
          void'(sb_q.pop_front());
        end
        check("index_xor", 64'(index_xor(hammingCode[12:1])), 64'(0));
`ifdef HAMMING_SECDED_EN
        check("overall_parity", 64'(^hammingCode), 64'(0));
`endif
        exp_count++;
      end
      if (out_valid_w4 && out_ready) begin
        check("w4_index_xor", 64'(index_xor(code_w4[12:1])), 64'(0));
      end
      if (in_valid && in_ready) sb_q.push_back(D);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_code", 64'(hammingCode), 64'(0));
    check("rst_count", 64'(word_count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Single word latency and encoding.
    tick();
    in_valid = 1'b1; D = 8'b10100001; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); @(negedge clk);
    check("a1_valid", 64'(out_valid), 64'(1));
    check("a1_code", 64'(hammingCode), 64'(EXP_A1));
    tick(); @(negedge clk);
    check("a1_count", 64'(word_count), 64'(1));
    check("a1_drained", 64'(out_valid), 64'(0));

    in_valid = 1'b1; D = 8'b01010110;
    tick(); in_valid = 1'b0;
    tick(); @(negedge clk);
    check("56_code", 64'(hammingCode), 64'(EXP_56));
    tick(); @(negedge clk);
    check("56_count", 64'(word_count), 64'(2));

    // Backpressure: fill both stages, hold, then release.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; D = 8'b10100001;
    tick(); D = 8'b01010110;
    @(negedge clk);
    check("stall_ready_one_full", 64'(in_ready), 64'(1));
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_code", 64'({out_valid, hammingCode}), 64'({1'b1, EXP_A1}));
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_first", 64'(hammingCode), 64'(EXP_A1));
    tick(); @(negedge clk);
    check("release_second", 64'({out_valid, hammingCode}), 64'({1'b1, EXP_56}));
    tick(); @(negedge clk);
    check("release_empty", 64'(out_valid), 64'(0));
    check("release_count", 64'(word_count), 64'(4));

    // All 256 words back-to-back: one codeword per cycle.
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; D = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); @(negedge clk);
    check("sweep_count", 64'(word_count), 64'(260));
    check("sweep_done", 64'(out_valid), 64'(0));
    check("sweep_sb_empty", 64'(sb_q.size()), 64'(0));

    // Reset with both stages full drops everything.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; D = 8'h3C;
    tick(); D = 8'hC3;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'(0));
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_count", 64'(word_count), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_w4_ready", 64'(in_ready_w4), 64'(1));
    out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("no_stale", 64'(out_valid), 64'(0));

    // 17 handshakes: the 4-bit counter wraps 15 -> 0 -> 1.
    tick();
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; D = 8'(8'h11 * k + 8'h05);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_15", 64'({count_w4, word_count}), 64'({4'd15, 16'd15}));
    tick(); @(negedge clk);
    check("wrap_0", 64'({count_w4, word_count}), 64'({4'd0, 16'd16}));
    tick(); @(negedge clk);
    check("wrap_1", 64'({count_w4, word_count}), 64'({4'd1, 16'd17}));

    // Random valid/ready toggling over 1000 words.
    tick();
    sent = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || sb_q.size() > 0 || out_valid); cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; D = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rand_sent", 64'(sent), 64'(1000));
    check("rand_sb_empty", 64'(sb_q.size()), 64'(0));
    check("rand_count", 64'(word_count), 64'(exp_count[15:0]));
    check("rand_count_w4", 64'(count_w4), 64'(exp_count[3:0]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
